// File: rtl/prime_pkg.sv
// rtl/prime_pkg.sv - shared widths, state encoding and select patterns for the prime sequencer
package prime_pkg;

  localparam int W_DEF     = 8;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_LOOP  = 3'd2,
    ST_BUMP  = 3'd3,
    ST_LATCH = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  typedef struct packed {
    logic a1;
    logic a2;
    logic a3;
    logic a4;
    logic a5;
    logic a6;
    logic a7;
  } sel_t;

  // A<=n, K<=n-1, C<=1, E and P held
  localparam sel_t SEL_LOAD = 7'b0001001;
  // A<=n (harmless), K, E, C, P held
  localparam sel_t SEL_HOLD = 7'b0101011;

endpackage

// File: rtl/prime_cycle_counter.sv
// rtl/prime_cycle_counter.sv - saturating busy-cycle counter with synchronous clear and enable
module prime_cycle_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/prime_seq_ctrl.sv
// rtl/prime_seq_ctrl.sv - trial-division primality sequencer; PRIME_EARLY_EXIT_EN adds BUMP early exit
// Selects decode combinationally from state and A/K; handshake outputs are registered.
module prime_seq_ctrl
  import prime_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     n,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     K,
  output logic             a1,
  output logic             a2,
  output logic             a3,
  output logic             a4,
  output logic             a5,
  output logic             a6,
  output logic             a7,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycles
);

  state_t state;
  sel_t   sel;
  logic   accept;
  logic   a_lt_k;
  logic   hit;
  logic   k_last;

  assign accept = (state == ST_IDLE) && start;
  assign a_lt_k = (A < K);
  assign hit    = (A == '0);
  assign k_last = (K == W'(1));

  always_comb begin
    sel = SEL_LOAD;
    case (state)
      ST_LOOP: begin
        if (!a_lt_k) begin
          sel.a1 = 1'b1;
          sel.a2 = 1'b1;
          sel.a6 = 1'b1;
        end else begin
          // close cycle: reload A from n, step K down, count a hit
          sel.a3 = 1'b1;
          if (hit) sel.a5 = 1'b1;
          else     sel.a6 = 1'b1;
        end
      end
`ifdef PRIME_EARLY_EXIT_EN
      ST_BUMP: begin
        sel.a2 = 1'b1;
        sel.a5 = 1'b1;
      end
`endif
      ST_LATCH: begin
        sel.a2 = 1'b1;
        sel.a6 = 1'b1;
        sel.a7 = 1'b0;
      end
      ST_DONE: sel = SEL_HOLD;
      default: sel = SEL_LOAD;
    endcase
  end

  assign {a1, a2, a3, a4, a5, a6, a7} = sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
      ready <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_INIT: begin
          state <= ST_IDLE;
          ready <= 1'b1;
        end
        ST_IDLE: begin
          if (start) begin
            ready <= 1'b0;
            busy  <= 1'b1;
            state <= (n < W'(2)) ? ST_LATCH : ST_LOOP;
          end
        end
        ST_LOOP: begin
          if (a_lt_k) begin
            if (k_last) begin
              state <= ST_LATCH;
            end
`ifdef PRIME_EARLY_EXIT_EN
            else if (hit) begin
              state <= ST_BUMP;
            end
`endif
          end
        end
`ifdef PRIME_EARLY_EXIT_EN
        ST_BUMP: state <= ST_LATCH;
`endif
        ST_LATCH: begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= ST_INIT;
          ready <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  prime_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (busy),
    .count (cycles)
  );

endmodule

// File: tb/tb_prime_seq_ctrl.sv
// tb/tb_prime_seq_ctrl.sv - scoreboard bench for prime_seq_ctrl with a behavioural datapath
module tb_prime_seq_ctrl;

  localparam int W     = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [W-1:0]     n;
  logic [W-1:0]     dp_a, dp_k, dp_c;
  logic             dp_p;
  logic             a1, a2, a3, a4, a5, a6, a7;
  logic             ready, busy, done;
  logic [CNT_W-1:0] cycles;

  typedef struct {
    int p;
    int cyc;
    int nv;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  int   lat = 0;
  bit   lat_on = 0;

  always #5 clk = ~clk;

  prime_seq_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .n      (n),
    .A      (dp_a),
    .K      (dp_k),
    .a1     (a1),
    .a2     (a2),
    .a3     (a3),
    .a4     (a4),
    .a5     (a5),
    .a6     (a6),
    .a7     (a7),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .cycles (cycles)
  );

  // datapath registers steered by the select lines (no reset, as in hardware)
  always @(posedge clk) begin
    dp_a <= a1 ? dp_a - dp_k : n;
    dp_k <= a2 ? dp_k : (a3 ? dp_k - 8'd1 : n - 8'd1);
    dp_c <= a6 ? dp_c : (a5 ? dp_c + 8'd1 : 8'd1);
    dp_p <= a7 ? dp_p : (dp_c == 8'd2);
  end

  function automatic exp_t model(input int nv);
    exp_t r;
    int   c;
    c     = 1;
    r.cyc = 0;
    r.nv  = nv;
    if (nv >= 2) begin
      for (int k = nv - 1; k >= 1; k--) begin
        r.cyc += nv / k + 1;
        if (nv % k == 0) begin
          c++;
`ifdef PRIME_EARLY_EXIT_EN
          if (k > 1) begin
            c++;
            r.cyc++;
            break;
          end
`endif
        end
      end
    end
    r.cyc += 1;
    if (r.cyc > 65535) r.cyc = 65535;
    r.p = (c == 2) ? 1 : 0;
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      lat_on = 0;
      exp_q.delete();
    end else begin
      if (lat_on) lat++;
      if (done) begin
        done_cnt++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_done: got done with no test outstanding, required none");
        end else begin
          e = exp_q.pop_front();
          if (dp_p !== e.p[0]) begin
            n_bad++;
            $display("FAIL prime_flag n=%0d: got P=%b, required %0d", e.nv, dp_p, e.p);
          end
          n_cmp++;
          if (cycles !== e.cyc[CNT_W-1:0]) begin
            n_bad++;
            $display("FAIL cycle_count n=%0d: got %0d, required %0d", e.nv, cycles, e.cyc);
          end
          n_cmp++;
          if (lat != e.cyc + 1) begin
            n_bad++;
            $display("FAIL done_latency n=%0d: got %0d, required %0d", e.nv, lat, e.cyc + 1);
          end
          lat_on = 0;
        end
      end
      if (start && ready) begin
        exp_q.push_back(model(int'(n)));
        lat_on = 1;
        lat    = 0;
      end
    end
  end

  task automatic run_one(input int nv, input int stray);
    int t;
    int d0;
    t = 0;
    @(posedge clk); #1;
    while (!ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    n_cmp++;
    if (!ready) begin
      n_bad++;
      $display("FAIL ready_timeout n=%0d: got ready=0, required 1", nv);
    end
    d0    = done_cnt;
    n     = W'(nv);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < stray; i++) begin
      @(posedge clk); #1;
      start = ~start;
    end
    start = 1'b0;
    t = 0;
    while (done_cnt == d0 && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    n_cmp++;
    if (done_cnt != d0 + 1) begin
      n_bad++;
      $display("FAIL done_count n=%0d: got %0d pulses, required 1", nv, done_cnt - d0);
    end
    n_cmp++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL after_done n=%0d: got ready=%b busy=%b done=%b, required 1 0 0", nv, ready, busy, done);
    end
  endtask

  task automatic test_reset();
    int t;
    int d0;
    rst   = 1'b1;
    start = 1'b1;
    n     = 8'd2;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cycles !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got ready=%b busy=%b done=%b cycles=%0d, required 0 0 0 0", ready, busy, done, cycles);
    end
    n_cmp++;
    if ({a1, a2, a3, a4, a5, a6, a7} !== 7'b0001001) begin
      n_bad++;
      $display("FAIL reset_selects: got %b, required 0001001", {a1, a2, a3, a4, a5, a6, a7});
    end
    d0  = done_cnt;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ready !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL init_cycle: got ready=%b busy=%b, required 0 0", ready, busy);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_init: got ready=%b busy=%b, required 1 0", ready, busy);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      n_bad++;
      $display("FAIL accept_held_start: got busy=%b ready=%b, required 1 0", busy, ready);
    end
    start = 1'b0;
    t = 0;
    while (done_cnt == d0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    n_cmp++;
    if (done_cnt != d0 + 1) begin
      n_bad++;
      $display("FAIL reset_run_done: got %0d pulses, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_small();
    run_one(2, 0);
    run_one(4, 0);
    run_one(0, 0);
    run_one(1, 0);
  endtask

  task automatic test_large();
    exp_t e;
    run_one(251, 0);
    run_one(255, 6);
    e = model(255);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (cycles !== e.cyc[CNT_W-1:0]) begin
      n_bad++;
      $display("FAIL cycles_held: got %0d, required %0d", cycles, e.cyc);
    end
  endtask

  task automatic test_back_to_back();
    int list [6] = '{3, 6, 9, 13, 16, 17};
    foreach (list[i]) run_one(list[i], 0);
  endtask

  task automatic test_abort();
    int d0;
    int t;
    d0 = done_cnt;
    t  = 0;
    @(posedge clk); #1;
    while (!ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    n     = 8'd97;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || ready !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_outputs: got busy=%b ready=%b done=%b, required 0 0 0", busy, ready, done);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (done_cnt != d0) begin
      n_bad++;
      $display("FAIL abort_no_done: got %0d pulses, required 0", done_cnt - d0);
    end
    run_one(97, 0);
  endtask

  initial begin
    test_reset();
    test_small();
    test_large();
    test_back_to_back();
    test_abort();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
